// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes, FSM states and the latched operation context.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic is_div;
        logic s1;
        logic s2;
    } ctx_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude conversion and final sign correction for ex_muldiv.
// Purely combinational; both halves share one instance.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             signed_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_a,
    output logic             neg_b,
    input  logic             is_div,
    input  logic             res_neg_a,
    input  logic             res_neg_b,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic               neg_q;

    always_comb begin
        neg_a = signed_op & opa[WIDTH-1];
        neg_b = signed_op & opb[WIDTH-1];
        mag_a = neg_a ? -opa : opa;
        mag_b = neg_b ? -opb : opb;
    end

    // Remainder follows the dividend; quotient/product follow sign xor.
    always_comb begin
        neg_q    = res_neg_a ^ res_neg_b;
        prod     = {raw_hi, raw_lo};
        prod_fix = neg_q ? -prod : prod;
        if (is_div) begin
            res_lo = neg_q ? -raw_lo : raw_lo;
            res_hi = res_neg_a ? -raw_hi : raw_hi;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply / restoring divide for the EX stage.
// Define MULDIV_DIV_EN to build the divider and the DIVU/DIV ops.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    ctx_t             ctx;
    logic             wr_q;
    logic             accept;
    logic             skip;
    logic             last;

    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   mul_sum;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign accept = (state == ST_IDLE) & start_i & ~cancel_i;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] div_sh;
    logic [WIDTH:0] div_df;

    assign skip = op_is_div(op_i) & (reg2_i == '0);
`else
    assign skip = op_is_div(op_i);
`endif

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .signed_op(op_is_signed(op_i)),
        .opa      (reg1_i),
        .opb      (reg2_i),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .neg_a    (neg_a),
        .neg_b    (neg_b),
        .is_div   (ctx.is_div),
        .res_neg_a(ctx.s1),
        .res_neg_b(ctx.s2),
        .raw_hi   (step_hi),
        .raw_lo   (step_lo),
        .res_hi   (fix_hi),
        .res_lo   (fix_lo)
    );

    // One iteration: shift-add multiply or restoring divide step.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_sh = {acc_hi, acc_lo[WIDTH-1]};
        div_df = div_sh - {1'b0, opnd};
        if (ctx.is_div) begin
            step_hi = div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_df[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = skip ? ST_DONE : ST_CALC;
            ST_CALC: if (last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (cancel_i) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy_o  = (state != ST_IDLE);
        stall_o = accept | (state == ST_CALC);
        done_o  = (state == ST_DONE) & ~cancel_i;
        whilo_o = done_o & wr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ctx    <= '0;
            wr_q   <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (accept) begin
            cnt    <= '0;
            acc_hi <= '0;
            wr_q   <= 1'b1;
            ctx.s1 <= neg_a;
            ctx.s2 <= neg_b;
`ifdef MULDIV_DIV_EN
            ctx.is_div <= op_is_div(op_i);
`else
            ctx.is_div <= 1'b0;
`endif
            if (op_is_div(op_i)) begin
                opnd   <= mag_b;
                acc_lo <= mag_a;
            end else begin
                opnd   <= mag_a;
                acc_lo <= mag_b;
            end
            if (skip) begin
`ifdef MULDIV_DIV_EN
                hi_o <= reg1_i;
                lo_o <= '1;
`else
                wr_q <= 1'b0;
                hi_o <= '0;
                lo_o <= '0;
`endif
            end
        end else if (state == ST_CALC) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last && !cancel_i) begin
                hi_o <= fix_hi;
                lo_o <= fix_lo;
            end
        end
    end

endmodule
